frame_render_scheduler: RTL and testbench
=========================================

# frame_render_scheduler

Sequences the FrameEncoder once per display frame and ping-pongs its SRAM output between two frame buffers. On each display vsync it latches the current car angles, pulses the encoder start, waits for encoder done, then swaps write and read banks so the display always scans a completed frame. It sits between the game-state logic, the FrameEncoder and the SRAM/display path. It also reports overruns, meaning a vsync that arrives while a render is still in progress, and encoder timeouts.

## Interface
- TIMEOUT_CYCLES, default 2_000_000: cycles allowed in RENDER before the frame is abandoned.
- i_clk  in  1: system clock, all logic on rising edge.
- i_rst  in  1: synchronous, active-high reset.
- i_enable  in  1: scheduler run enable.
- i_vsync_pulse  in  1: one-cycle pulse at start of display vblank.
- i_car1_angle  in  32 (signed): live car 1 angle.
- i_car2_angle  in  32 (signed): live car 2 angle.
- i_enc_done  in  1: FrameEncoder completion pulse.
- i_enc_sram_addr  in  20: FrameEncoder raw write address.
- o_enc_start  out  1: one-cycle start pulse to FrameEncoder.
- o_enc_car1_angle  out  32 (signed): angle held stable for the whole render.
- o_enc_car2_angle  out  32 (signed): angle held stable for the whole render.
- o_sram_wr_addr  out  20: {o_wr_bank, i_enc_sram_addr[18:0]}, combinational.
- o_wr_bank  out  1: bank being rendered.
- o_rd_bank  out  1: bank the display scans; always equals ~o_wr_bank.
- o_busy  out  1: high in START, RENDER and SWAP.
- o_frame_count  out  16: completed frames, wraps 0xFFFF to 0.
- o_overrun  out  1: one-cycle pulse per overrun.
- o_overrun_count  out  16: overruns, saturates at 0xFFFF.
- o_timeout  out  1: one-cycle pulse when a render is abandoned.

## Operation
- States: IDLE, WAIT_VS, START, RENDER, SWAP.
- IDLE: if i_enable=1, go to WAIT_VS.
- WAIT_VS:
  - i_enable=0: go to IDLE.
  - i_vsync_pulse=1: latch both angles into o_enc_car*_angle and go to START.
- START: o_enc_start=1 for exactly this cycle, timeout counter cleared, go to RENDER.
- RENDER:
  - i_enc_done=1: go to SWAP.
  - Else timeout counter = TIMEOUT_CYCLES-1: pulse o_timeout, go to WAIT_VS (IDLE if i_enable=0). No bank swap, no frame_count increment.
  - Else increment the timeout counter.
  - i_vsync_pulse without i_enc_done in the same cycle: pulse o_overrun, increment o_overrun_count (saturating), stay in RENDER.
- SWAP:
  - Toggle o_wr_bank and o_rd_bank.
  - Increment o_frame_count.
  - Next state: START if the pending flag is set (i_enable ignored), else WAIT_VS if i_enable=1, else IDLE.
- Pending flag:
  - Set by i_vsync_pulse coinciding with i_enc_done in RENDER, or by i_vsync_pulse during SWAP.
  - When set, angles are latched on that vsync cycle.
  - Cleared on entry to START.
  - A done+vsync coincidence is not an overrun.
- i_enable deassertion during START/RENDER/SWAP does not abort: the current frame completes, then the block goes to IDLE.
- i_enc_done outside RENDER is ignored.
- Angles are latched only on the vsync events described above; otherwise they are held.
- Timeout counter width: $clog2(TIMEOUT_CYCLES).

## Timing
- Reset values:
  - State IDLE, pending flag 0, timeout counter 0.
  - o_enc_start 0, angles 0, o_wr_bank 0, o_rd_bank 1, o_busy 0.
  - o_frame_count 0, o_overrun 0, o_overrun_count 0, o_timeout 0.
- i_rst asserted mid-render forces all reset values on the next edge. A later i_enc_done is then ignored.
- Vsync at cycle t in WAIT_VS:
  - o_enc_start=1 and new angles visible at t+1.
  - RENDER at t+2.
- Done at cycle d in RENDER:
  - SWAP at d+1.
  - Banks and o_frame_count updated and visible at d+2.
  - With pending set, o_enc_start=1 at d+2.
- All outputs are registered except o_sram_wr_addr, which is combinational from i_enc_sram_addr and o_wr_bank.
- The bank swap never occurs mid-render, so o_sram_wr_addr's bank bit is constant from START through RENDER.

## Test plan
- Reset, i_enable=1, vsync at cycle 10 with angles 60/120 -> o_enc_start high only at cycle 11; angles 60/120 held; o_wr_bank=0, o_rd_bank=1.
- Done 50 cycles after start -> o_wr_bank=1, o_rd_bank=0, o_frame_count=1 two cycles after done. i_enc_sram_addr=0x00123 -> o_sram_wr_addr=0x80123 after swap.
- Two vsyncs during one render -> two o_overrun pulses, o_overrun_count=2, banks unchanged until done.
- Vsync and done in the same cycle with angles 30/90 -> no overrun; SWAP then START directly; angles 30/90.
- TIMEOUT_CYCLES=100, encoder never done -> o_timeout pulse 100 cycles after RENDER entry; state WAIT_VS; o_frame_count and banks unchanged.
- i_rst pulsed mid-render, then late i_enc_done -> all reset values; no swap; state IDLE, then WAIT_VS on the next cycle with i_enable=1.

Source files
------------

// File: rtl/frame_render_scheduler.sv
// ---------------------------------------------------------------------------
// frame_render_scheduler
//
// Runs the FrameEncoder once per display frame and ping-pongs its SRAM
// output between two frame buffers. On each vsync the current car angles
// are latched and the encoder is started. When the encoder reports done,
// the write and read banks swap, so the display always scans a completed
// frame. Overruns (a vsync while a render is still running) and encoder
// timeouts are reported as one-cycle pulses.
//
// Ports
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_enable             scheduler run enable
//   i_vsync_pulse        one-cycle pulse at the start of display vblank
//   i_car1/2_angle       live car angles (signed)
//   i_enc_done           FrameEncoder completion pulse
//   i_enc_sram_addr      FrameEncoder raw write address
//   o_enc_start          one-cycle start pulse to the FrameEncoder
//   o_enc_car1/2_angle   angles held stable for the whole render
//   o_sram_wr_addr       {o_wr_bank, i_enc_sram_addr[18:0]} (combinational)
//   o_wr_bank/o_rd_bank  bank being rendered / bank being scanned
//   o_busy               high in START, RENDER and SWAP
//   o_frame_count        completed frames (wraps)
//   o_overrun(_count)    overrun pulse / saturating overrun count
//   o_timeout            pulse when a render is abandoned
// ---------------------------------------------------------------------------
module frame_render_scheduler #(
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_enable,
  input  logic               i_vsync_pulse,
  input  logic signed [31:0] i_car1_angle,
  input  logic signed [31:0] i_car2_angle,
  input  logic               i_enc_done,
  input  logic        [19:0] i_enc_sram_addr,
  output logic               o_enc_start,
  output logic signed [31:0] o_enc_car1_angle,
  output logic signed [31:0] o_enc_car2_angle,
  output logic        [19:0] o_sram_wr_addr,
  output logic               o_wr_bank,
  output logic               o_rd_bank,
  output logic               o_busy,
  output logic        [15:0] o_frame_count,
  output logic               o_overrun,
  output logic        [15:0] o_overrun_count,
  output logic               o_timeout
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_VS,
    S_START,
    S_RENDER,
    S_SWAP
  } state_e;

  state_e             state_q, state_d;
  logic               pending_q, pending_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic signed [31:0] car1_q, car1_d;
  logic signed [31:0] car2_q, car2_d;
  logic               wr_bank_q, wr_bank_d;
  logic [15:0]        frame_q, frame_d;
  logic [15:0]        ovr_cnt_q, ovr_cnt_d;
  logic               start_q, start_d;
  logic               busy_q, busy_d;
  logic               overrun_q, overrun_d;
  logic               timeout_q, timeout_d;

  // The encoder's own bank bit is replaced by ours.
  logic unused_addr_msb;
  assign unused_addr_msb = i_enc_sram_addr[19];

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    car1_d    = car1_q;
    car2_d    = car2_q;
    wr_bank_d = wr_bank_q;
    frame_d   = frame_q;
    ovr_cnt_d = ovr_cnt_q;
    overrun_d = 1'b0;
    timeout_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_enable) state_d = S_WAIT_VS;
      end

      S_WAIT_VS: begin
        if (!i_enable) begin
          state_d = S_IDLE;
        end else if (i_vsync_pulse) begin
          car1_d  = i_car1_angle;
          car2_d  = i_car2_angle;
          state_d = S_START;
        end
      end

      S_START: begin
        cnt_d   = '0;
        state_d = S_RENDER;
      end

      S_RENDER: begin
        if (i_enc_done) begin
          state_d = S_SWAP;
          // A vsync arriving with done is simply the next frame, queued.
          if (i_vsync_pulse) begin
            pending_d = 1'b1;
            car1_d    = i_car1_angle;
            car2_d    = i_car2_angle;
          end
        end else begin
          if (cnt_q == CNT_LAST) begin
            timeout_d = 1'b1;
            state_d   = i_enable ? S_WAIT_VS : S_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (i_vsync_pulse) begin
            overrun_d = 1'b1;
            ovr_cnt_d = sat_inc16(ovr_cnt_q);
          end
        end
      end

      S_SWAP: begin
        wr_bank_d = ~wr_bank_q;
        frame_d   = frame_q + 16'd1;
        if (i_vsync_pulse) begin
          car1_d = i_car1_angle;
          car2_d = i_car2_angle;
        end
        // A vsync in this very cycle counts as pending, otherwise it would be lost.
        if (pending_q || i_vsync_pulse) state_d = S_START;
        else if (i_enable)              state_d = S_WAIT_VS;
        else                            state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    if (state_d == S_START) pending_d = 1'b0;

    start_d = (state_d == S_START);
    busy_d  = (state_d == S_START) || (state_d == S_RENDER) || (state_d == S_SWAP);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      pending_q <= 1'b0;
      cnt_q     <= '0;
      car1_q    <= '0;
      car2_q    <= '0;
      wr_bank_q <= 1'b0;
      frame_q   <= '0;
      ovr_cnt_q <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      car1_q    <= car1_d;
      car2_q    <= car2_d;
      wr_bank_q <= wr_bank_d;
      frame_q   <= frame_d;
      ovr_cnt_q <= ovr_cnt_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_enc_start      = start_q;
  assign o_enc_car1_angle = car1_q;
  assign o_enc_car2_angle = car2_q;
  assign o_wr_bank        = wr_bank_q;
  assign o_rd_bank        = ~wr_bank_q;
  assign o_sram_wr_addr   = {wr_bank_q, i_enc_sram_addr[18:0]};
  assign o_busy           = busy_q;
  assign o_frame_count    = frame_q;
  assign o_overrun        = overrun_q;
  assign o_overrun_count  = ovr_cnt_q;
  assign o_timeout        = timeout_q;

endmodule

// File: tb/tb_frame_render_scheduler.sv
module tb_frame_render_scheduler;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic               vsync;
  logic signed [31:0] car1, car2;
  logic               done;
  logic        [19:0] enc_addr;
  logic               enc_start;
  logic signed [31:0] enc_car1, enc_car2;
  logic        [19:0] sram_addr;
  logic               wr_bank, rd_bank, busy, overrun, timeout;
  logic        [15:0] frame_count, overrun_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  frame_render_scheduler #(.TIMEOUT_CYCLES(100)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_enable         (enable),
    .i_vsync_pulse    (vsync),
    .i_car1_angle     (car1),
    .i_car2_angle     (car2),
    .i_enc_done       (done),
    .i_enc_sram_addr  (enc_addr),
    .o_enc_start      (enc_start),
    .o_enc_car1_angle (enc_car1),
    .o_enc_car2_angle (enc_car2),
    .o_sram_wr_addr   (sram_addr),
    .o_wr_bank        (wr_bank),
    .o_rd_bank        (rd_bank),
    .o_busy           (busy),
    .o_frame_count    (frame_count),
    .o_overrun        (overrun),
    .o_overrun_count  (overrun_count),
    .o_timeout        (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_start"},   32'(enc_start), 32'd0);
    chk({pfx, "_car1"},    enc_car1, 32'd0);
    chk({pfx, "_car2"},    enc_car2, 32'd0);
    chk({pfx, "_wr"},      32'(wr_bank), 32'd0);
    chk({pfx, "_rd"},      32'(rd_bank), 32'd1);
    chk({pfx, "_busy"},    32'(busy), 32'd0);
    chk({pfx, "_frames"},  32'(frame_count), 32'd0);
    chk({pfx, "_ovr"},     32'(overrun), 32'd0);
    chk({pfx, "_ovrcnt"},  32'(overrun_count), 32'd0);
    chk({pfx, "_tmo"},     32'(timeout), 32'd0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; vsync = 1'b0; done = 1'b0;
    car1 = 0; car2 = 0; enc_addr = 20'h0;
    tick(2);
    chk_reset_vals("rst");

    // Start of a frame: vsync in WAIT_VS latches the angles.
    rst = 1'b0; enable = 1'b1;
    tick();                                 // IDLE -> WAIT_VS
    chk("idle_no_start", 32'(enc_start), 32'd0);
    car1 = 60; car2 = 120; vsync = 1'b1;
    tick();                                 // -> START
    vsync = 1'b0; car1 = 5; car2 = 6;
    chk("start_pulse", 32'(enc_start), 32'd1);
    chk("start_car1", enc_car1, 32'd60);
    chk("start_car2", enc_car2, 32'd120);
    chk("start_busy", 32'(busy), 32'd1);
    tick();                                 // -> RENDER
    chk("render_start_low", 32'(enc_start), 32'd0);
    chk("render_car1_held", enc_car1, 32'd60);
    chk("render_car2_held", enc_car2, 32'd120);
    chk("render_wr", 32'(wr_bank), 32'd0);
    chk("render_rd", 32'(rd_bank), 32'd1);
    enc_addr = 20'h00123;
    #1 chk("addr_bank0", 32'(sram_addr), 32'h00123);

    // Done 50 cycles after the start pulse.
    tick(48);
    chk("no_early_swap", 32'(wr_bank), 32'd0);
    done = 1'b1;
    tick();                                 // -> SWAP
    done = 1'b0;
    chk("swap_frames_old", 32'(frame_count), 32'd0);
    chk("swap_busy", 32'(busy), 32'd1);
    tick();                                 // -> WAIT_VS, swap visible
    chk("done_wr", 32'(wr_bank), 32'd1);
    chk("done_rd", 32'(rd_bank), 32'd0);
    chk("done_frames", 32'(frame_count), 32'd1);
    chk("addr_bank1", 32'(sram_addr), 32'h80123);
    chk("done_idle_busy", 32'(busy), 32'd0);

    // Two vsyncs during one render.
    car1 = 1; car2 = 2; vsync = 1'b1;
    tick();                                 // -> START
    vsync = 1'b0;
    tick();                                 // -> RENDER
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    chk("ovr1_pulse", 32'(overrun), 32'd1);
    chk("ovr1_count", 32'(overrun_count), 32'd1);
    tick();
    chk("ovr_pulse_gone", 32'(overrun), 32'd0);
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    chk("ovr2_pulse", 32'(overrun), 32'd1);
    chk("ovr2_count", 32'(overrun_count), 32'd2);
    chk("ovr_bank_held", 32'(wr_bank), 32'd1);
    chk("ovr_car1_held", enc_car1, 32'd1);

    // Vsync coinciding with done: not an overrun, SWAP then START.
    car1 = 30; car2 = 90; vsync = 1'b1; done = 1'b1;
    tick();                                 // -> SWAP
    vsync = 1'b0; done = 1'b0;
    chk("coinc_no_ovr", 32'(overrun), 32'd0);
    chk("coinc_ovrcnt", 32'(overrun_count), 32'd2);
    chk("coinc_car1", enc_car1, 32'd30);
    chk("coinc_car2", enc_car2, 32'd90);
    tick();                                 // -> START directly
    chk("coinc_start", 32'(enc_start), 32'd1);
    chk("coinc_wr", 32'(wr_bank), 32'd0);
    chk("coinc_frames", 32'(frame_count), 32'd2);
    tick();                                 // -> RENDER, counter at 0
    chk("coinc_render_start_low", 32'(enc_start), 32'd0);

    // Encoder never completes: timeout 100 cycles after RENDER entry.
    tick(99);
    chk("tmo_not_yet", 32'(timeout), 32'd0);
    chk("tmo_busy_before", 32'(busy), 32'd1);
    tick();
    chk("tmo_pulse", 32'(timeout), 32'd1);
    chk("tmo_busy", 32'(busy), 32'd0);
    chk("tmo_frames", 32'(frame_count), 32'd2);
    chk("tmo_wr", 32'(wr_bank), 32'd0);
    tick();
    chk("tmo_pulse_gone", 32'(timeout), 32'd0);
    car1 = -7; car2 = 8; vsync = 1'b1;      // WAIT_VS accepts a vsync at once
    tick();
    vsync = 1'b0;
    chk("tmo_waitvs_start", 32'(enc_start), 32'd1);
    chk("tmo_neg_car1", enc_car1, 32'hFFFF_FFF9);

    // Reset mid-render, then a late done.
    tick(5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_vals("midrst");
    done = 1'b1;
    tick();                                 // IDLE -> WAIT_VS, done ignored
    done = 1'b0;
    chk("late_done_frames", 32'(frame_count), 32'd0);
    chk("late_done_wr", 32'(wr_bank), 32'd0);
    chk("late_done_busy", 32'(busy), 32'd0);
    car1 = 11; car2 = 22; vsync = 1'b1;
    tick();
    vsync = 1'b0;
    chk("post_rst_start", 32'(enc_start), 32'd1);
    chk("post_rst_car2", enc_car2, 32'd22);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
